// File: rtl/wavetable_pkg.sv
// wavetable_pkg: shared FSM encodings, channel-width helper and interpolation fraction width
package wavetable_pkg;
  localparam int INTERP_FRAC_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t ACC  = 2'd2;
  localparam state_t OUT  = 2'd3;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wavetable_ram.sv
// wavetable_ram: single-port byte-enable table RAM with registered read-before-write output
module wavetable_ram import wavetable_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (en) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (we && be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      q <= mem[addr];
    end
endmodule

// File: rtl/wavetable_bank.sv
// wavetable_bank: multi-channel wavetable store, host port and mixing scan engine.
// Define WAVETABLE_LINEAR_INTERP_EN for two-tap linear interpolation (2 scan cycles per channel).
module wavetable_bank import wavetable_pkg::*; #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [CH_W+ADDR_W-1:0]    avs_address,
  input  logic                      avs_chipselect,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_W-1:0]         avs_writedata,
  input  logic [DATA_W/8-1:0]       avs_byteenable,
  output logic [DATA_W-1:0]         avs_readdata,
  output logic                      avs_readdatavalid,
  output logic                      avs_waitrequest,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*PHASE_W-1:0] ch_inc,
  input  logic                      sample_tick,
  output logic [DATA_W+CH_W-1:0]    mix_data,
  output logic                      mix_valid,
  input  logic                      mix_ready,
  output logic                      overrun,
  input  logic                      overrun_clr
);
`ifdef WAVETABLE_LINEAR_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif
  localparam int MIX_W = DATA_W + CH_W;
  state_t state;
  logic [CH_W-1:0] ch, pch, rch, hch;
  logic hi, cur_en, pend, eng_active, host_sel, host_ok, done, accept, drop;
  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [ADDR_W-1:0] nidx, cur_idx, eng_addr, hidx;
  logic [INTERP_FRAC_W-1:0] frac;
  logic signed [DATA_W-1:0] s0, s1, sample;
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W+INTERP_FRAC_W+1:0] prod;
  logic [MIX_W-1:0] acc;
  logic [DATA_W-1:0] ram_q [NUM_CH];
  // hi marks the second (idx+1) read of a channel; it never sets without interpolation
  always_comb begin
    cur_idx = phase[ch][PHASE_W-1 -: ADDR_W];
    eng_active = state == SCAN && (hi ? cur_en : ch_en[ch]);
    eng_addr = hi ? nidx : cur_idx;
    hch = avs_address[ADDR_W +: CH_W];
    hidx = avs_address[ADDR_W-1:0];
    host_sel = avs_chipselect && (avs_read || avs_write);
    avs_waitrequest = host_sel && eng_active && hch == ch;
    host_ok = host_sel && !avs_waitrequest;
    done = !INTERP || hi;
    accept = sample_tick && (state == IDLE || (state == OUT && mix_valid && mix_ready));
    drop = sample_tick && !accept;
    s1 = ram_q[pch];
    diff = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
    prod = diff * $signed({1'b0, frac});
    sample = INTERP ? DATA_W'(s0 + (prod >>> INTERP_FRAC_W)) : s1;
    avs_readdata = ram_q[rch];
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel_e, sel_h;
    assign sel_e = eng_active && ch == CH_W'(c);
    assign sel_h = host_ok && hch == CH_W'(c);
    wavetable_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk(clk_clk), .en(sel_e || sel_h), .we(sel_h && avs_write), .be(avs_byteenable),
      .addr(sel_e ? eng_addr : hidx), .wdata(avs_writedata), .q(ram_q[c])
    );
  end
  // pend qualifies the RAM output one cycle after an enabled read, so adds trail the scan by one cycle
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state <= IDLE;
      ch <= '0;
      pch <= '0;
      rch <= '0;
      hi <= 1'b0;
      cur_en <= 1'b0;
      pend <= 1'b0;
      nidx <= '0;
      frac <= '0;
      s0 <= '0;
      acc <= '0;
      mix_data <= '0;
      mix_valid <= 1'b0;
      overrun <= 1'b0;
      avs_readdatavalid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) phase[c] <= '0;
    end else begin
      avs_readdatavalid <= host_ok && avs_read;
      if (host_ok && avs_read) rch <= hch;
      overrun <= drop || (overrun && !overrun_clr);
      pend <= 1'b0;
      if (pend) acc <= acc + {{CH_W{sample[DATA_W-1]}}, sample};
      if (accept) begin
        state <= SCAN;
        ch <= '0;
        hi <= 1'b0;
        acc <= '0;
        mix_valid <= 1'b0;
      end else if (state == SCAN) begin
        if (!hi) begin
          cur_en <= ch_en[ch];
          nidx <= cur_idx + 1'b1;
          frac <= phase[ch][PHASE_W-ADDR_W-1 -: INTERP_FRAC_W];
          if (ch_en[ch]) phase[ch] <= phase[ch] + ch_inc[ch*PHASE_W +: PHASE_W];
        end else s0 <= ram_q[ch];
        pend <= INTERP ? hi && cur_en : ch_en[ch];
        pch <= ch;
        hi <= INTERP && !hi;
        if (done) begin
          ch <= ch + 1'b1;
          if (ch == CH_W'(NUM_CH-1)) state <= ACC;
        end
      end else if (state == ACC) state <= OUT;
      else if (state == OUT) begin
        if (!mix_valid) begin
          mix_data <= acc;
          mix_valid <= 1'b1;
        end else if (mix_ready) begin
          mix_valid <= 1'b0;
          state <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_wavetable_bank.sv
// tb_wavetable_bank: scoreboard bench for the wavetable bank host port and mixing engine
module tb_wavetable_bank;
  localparam int NUM_CH = 4;
  localparam int PHASE_W = 24;
`ifdef WAVETABLE_LINEAR_INTERP_EN
  localparam int SPC = 2;
`else
  localparam int SPC = 1;
`endif
  localparam int LAT = SPC*NUM_CH + 2;
  logic clk = 1'b0, rst_n;
  logic [9:0] avs_address;
  logic avs_chipselect, avs_read, avs_write;
  logic [15:0] avs_writedata, avs_readdata;
  logic [1:0] avs_byteenable;
  logic avs_readdatavalid, avs_waitrequest;
  logic [3:0] ch_en;
  logic [NUM_CH*PHASE_W-1:0] ch_inc;
  logic sample_tick, mix_valid, mix_ready, overrun, overrun_clr;
  logic [17:0] mix_data;
  wavetable_bank dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
    .ch_en(ch_en), .ch_inc(ch_inc), .sample_tick(sample_tick), .mix_data(mix_data),
    .mix_valid(mix_valid), .mix_ready(mix_ready), .overrun(overrun), .overrun_clr(overrun_clr)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { logic [31:0] d; int t; } exp_t;
  exp_t mix_q[$], rd_q[$];
  exp_t me, re;
  int checks = 0, passes = 0;
  logic prev_v = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    if (mix_valid && !prev_v) begin
      if (mix_q.size() == 0) chk("mix_unexpected", 32'd1, 32'd0);
      else begin
        me = mix_q.pop_front();
        chk("mix_data", 32'(mix_data), me.d);
        chk("mix_latency", 32'(cyc - me.t), 32'(LAT));
      end
    end
    prev_v = mix_valid;
    if (avs_readdatavalid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        re = rd_q.pop_front();
        chk("readdata", 32'(avs_readdata), re.d);
        chk("rd_latency", 32'(cyc - re.t), 32'd1);
      end
    end
  end
  task automatic host(input logic wr, input int c, input int idx, input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    @(negedge clk);
    avs_chipselect = 1'b1;
    avs_write = wr;
    avs_read = !wr;
    avs_address = {2'(c), 8'(idx)};
    avs_writedata = d;
    avs_byteenable = be;
    #1;
    while (avs_waitrequest && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (avs_waitrequest) chk("host_stall_timeout", 32'd1, 32'd0);
    else if (!wr) rd_q.push_back('{32'(d), cyc});
    @(posedge clk);
    #1;
    avs_chipselect = 1'b0;
    avs_write = 1'b0;
    avs_read = 1'b0;
  endtask
  task automatic tick(input logic [31:0] e);
    @(negedge clk);
    sample_tick = 1'b1;
    mix_q.push_back('{e, cyc + 1});
    @(negedge clk);
    sample_tick = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((mix_q.size() > 0 || rd_q.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mix_q.size() + rd_q.size() > 0) begin
      chk("drain_timeout", 32'(mix_q.size() + rd_q.size()), 32'd0);
      mix_q.delete();
      rd_q.delete();
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] v;
    rst_n = 1'b0;
    avs_address = '0;
    avs_chipselect = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    ch_en = '0;
    ch_inc = '0;
    sample_tick = 1'b0;
    mix_ready = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mix_valid", 32'(mix_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_readdatavalid", 32'(avs_readdatavalid), 32'd0);
    chk("rst_waitrequest", 32'(avs_waitrequest), 32'd0);
    chk("rst_mix_data", 32'(mix_data), 32'd0);
    // table load, readback and byte lanes
    for (int i = 0; i < 256; i++) host(1'b1, 0, i, 16'(i << 8), 2'b11);
    host(1'b0, 0, 5, 16'h0500, 2'b11);
    host(1'b1, 0, 5, 16'h12AB, 2'b01);
    host(1'b0, 0, 5, 16'h05AB, 2'b11);
    host(1'b1, 0, 6, 16'hCD34, 2'b10);
    host(1'b0, 0, 6, 16'hCD00, 2'b11);
    host(1'b1, 0, 5, 16'h0500, 2'b11);
    host(1'b1, 0, 6, 16'h0600, 2'b11);
    drain();
    // single channel sweep through the whole table and its index wrap
    ch_en = 4'b0001;
    ch_inc[23:0] = 24'h010000;
    mix_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      v = 16'((k % 256) << 8);
      tick({14'b0, {2{v[15]}}, v});
      repeat ((k < 4) ? 18 : 12) @(negedge clk);
    end
    drain();
    chk("sweep_no_overrun", 32'(overrun), 32'd0);
    // full-scale sums
    ch_inc = '0;
    for (int c = 0; c < 4; c++) for (int i = 0; i < 256; i++) host(1'b1, c, i, 16'h7FFF, 2'b11);
    ch_en = 4'b1111;
    tick(32'h1FFFC);
    drain();
    for (int c = 0; c < 4; c++) for (int i = 0; i < 256; i++) host(1'b1, c, i, 16'h8000, 2'b11);
    tick(32'h20000);
    drain();
    // backpressure, overrun and tick accepted on handshake
    mix_ready = 1'b0;
    tick(32'h20000);
    repeat (LAT + 2) @(negedge clk);
    chk("valid_held", 32'(mix_valid), 32'd1);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("mix_data_stable", 32'(mix_data), 32'h20000);
    @(negedge clk);
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    chk("overrun_clr_vs_drop", 32'(overrun), 32'd1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'd0);
    @(negedge clk);
    sample_tick = 1'b1;
    mix_ready = 1'b1;
    mix_q.push_back('{32'h20000, cyc + 1});
    @(negedge clk);
    sample_tick = 1'b0;
    chk("handshake_tick_no_overrun", 32'(overrun), 32'd0);
    drain();
    // host write colliding with the engine's ch1 read
    host(1'b1, 0, 1, 16'h0100, 2'b11);
    host(1'b1, 1, 0, 16'h0020, 2'b11);
    ch_en = 4'b0011;
    @(negedge clk);
    sample_tick = 1'b1;
    mix_q.push_back('{32'h120, cyc + 1});
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (SPC) @(negedge clk);
    avs_chipselect = 1'b1;
    avs_write = 1'b1;
    avs_address = {2'd1, 8'd0};
    avs_writedata = 16'h0300;
    avs_byteenable = 2'b11;
    #1;
    chk("wait_ch1", 32'(avs_waitrequest), 32'd1);
    for (int k = 1; k < SPC; k++) begin
      @(negedge clk);
      #1;
      chk("wait_ch1_second", 32'(avs_waitrequest), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("wait_ch2", 32'(avs_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    avs_chipselect = 1'b0;
    avs_write = 1'b0;
    drain();
    host(1'b0, 1, 0, 16'h0300, 2'b11);
    tick(32'h400);
    drain();
`ifdef WAVETABLE_LINEAR_INTERP_EN
    host(1'b1, 0, 1, 16'd0, 2'b11);
    host(1'b1, 0, 2, 16'd1000, 2'b11);
    ch_en = 4'b0001;
    ch_inc[23:0] = 24'h008000;
    tick(32'd0);
    drain();
    tick(32'd500);
    drain();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
